// File: rtl/speed_cmd_if.sv
// Command/feedback bundle between the driver-command logic, the sequencer
// and the speed controller's brake/accelerate inputs.
interface speed_cmd_if;
    logic       req_valid;
    logic [1:0] req_speed;
    logic       req_ready;
    logic [1:0] speed_fb;
    logic       abort;
    logic       accelerate;
    logic       brake;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [2:0] steps;

    modport slave (
        input  req_valid, req_speed, speed_fb, abort,
        output req_ready, accelerate, brake, busy, done, error, err_code, steps
    );

    modport master (
        output req_valid, req_speed, speed_fb, abort,
        input  req_ready, accelerate, brake, busy, done, error, err_code, steps
    );
endinterface

// File: rtl/speed_cmd_sequencer.sv
// Steps the car speed controller toward a requested target one accelerate/brake
// pulse at a time, confirming each step on the speed feedback.
module speed_cmd_sequencer #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input logic        clk,
    input logic        reset,
    speed_cmd_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       target_q, target_d;
    logic [1:0]       exp_q, exp_d;
    logic [1:0]       pre_q, pre_d;
    logic             accelerate_q, accelerate_d;
    logic             brake_q, brake_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [2:0]       steps_q, steps_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        exp_d        = exp_q;
        pre_d        = pre_q;
        accelerate_d = 1'b0;
        brake_d      = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        err_code_d   = err_code_q;
        steps_d      = steps_q;

        // Abort overrides whatever the active state would have done this edge.
        if (state_q != S_IDLE && bus.abort) begin
            state_d    = S_IDLE;
            error_d    = 1'b1;
            err_code_d = 2'b11;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        target_d   = bus.req_speed;
                        steps_d    = 3'd0;
                        err_code_d = 2'b00;
                        cnt_d      = '0;
                        state_d    = S_CHECK;
                    end
                end
                S_CHECK: begin
                    pre_d = bus.speed_fb;
                    if (bus.speed_fb == target_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (bus.speed_fb < target_q) begin
                        accelerate_d = 1'b1;
                        exp_d        = bus.speed_fb + 2'd1;
                        state_d      = S_PULSE;
                    end else begin
                        brake_d = 1'b1;
                        exp_d   = bus.speed_fb - 2'd1;
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    steps_d = (steps_q == 3'd7) ? 3'd7 : steps_q + 3'd1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A match beats the timeout when both land on the same edge.
                    if (bus.speed_fb == exp_q) begin
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else if (bus.speed_fb != pre_q) begin
                        error_d    = 1'b1;
                        err_code_d = 2'b10;
                        state_d    = S_IDLE;
                    end else if (cnt_q == TMO_LAST) begin
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            target_q     <= 2'b00;
            exp_q        <= 2'b00;
            pre_q        <= 2'b00;
            accelerate_q <= 1'b0;
            brake_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
            steps_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            exp_q        <= exp_d;
            pre_q        <= pre_d;
            accelerate_q <= accelerate_d;
            brake_q      <= brake_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            steps_q      <= steps_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.accelerate = accelerate_q;
    assign bus.brake      = brake_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;
    assign bus.steps      = steps_q;
endmodule
